// File: rtl/loopy_gen_v2_if.sv
// Bundle between CPU register decode / PPU timing and the loopy scroll unit.
interface loopy_gen_v2_if;
  logic        ce;
  logic        is_rendering;
  logic        is_pre_render;
  logic [8:0]  cycle;
  logic [2:0]  ain;
  logic [7:0]  din;
  logic        read;
  logic        write;
  logic [14:0] loopy;
  logic [2:0]  fine_x_scroll;
  logic        write_toggle;
  logic        v_load_pending;

  modport master (
    output ce, is_rendering, is_pre_render, cycle, ain, din, read, write,
    input  loopy, fine_x_scroll, write_toggle, v_load_pending
  );

  modport slave (
    input  ce, is_rendering, is_pre_render, cycle, ain, din, read, write,
    output loopy, fine_x_scroll, write_toggle, v_load_pending
  );
endinterface

// File: rtl/loopy_gen_v2.sv
// PPU loopy v/t/fine-X/toggle registers with render-time increments and copies.
// All outputs registered: one clk after the qualifying ce edge; no backpressure.
module loopy_gen_v2 #(
  parameter int V_ROWS       = 30,
  parameter int V_LOAD_DELAY = 3,
  parameter int GLITCH_2007  = 1
) (
  input  logic           clk,
  input  logic           reset_n,
  loopy_gen_v2_if.slave  lbus
);

  localparam logic [4:0] LP_LAST_ROW = 5'(V_ROWS - 1);
  localparam logic [2:0] LP_DELAY    = 3'(V_LOAD_DELAY);
  localparam bit         LP_GLITCH   = (GLITCH_2007 != 0);

  logic [14:0] r_v, r_t, r_staged;
  logic [2:0]  r_fine_x, r_cnt;
  logic        r_toggle, r_incr32, r_pending;

  logic [14:0] w_v_nxt, w_t_nxt, w_staged_nxt, w_v_render, w_v_glitch;
  logic [2:0]  w_fine_x_nxt, w_cnt_nxt;
  logic        w_toggle_nxt, w_incr32_nxt, w_pending_nxt;
  logic        w_wr, w_rd, w_acc_2007, w_wr6_second, w_load_done;
  logic        w_x_dot, w_y_dot, w_h_dot, w_v_copy;

  function automatic logic [14:0] f_inc_x(input logic [14:0] v);
    logic [14:0] r;
    r = v;
    if (v[4:0] == 5'd31) begin
      r[4:0] = 5'd0;
      r[10]  = ~v[10];
    end else begin
      r[4:0] = v[4:0] + 5'd1;
    end
    return r;
  endfunction

  // Rows past the visible area (e.g. 30/31 with V_ROWS=30) wrap without flipping the nametable.
  function automatic logic [14:0] f_inc_y(input logic [14:0] v);
    logic [14:0] r;
    r = v;
    if (v[14:12] != 3'd7) begin
      r[14:12] = v[14:12] + 3'd1;
    end else begin
      r[14:12] = 3'd0;
      if (v[9:5] == LP_LAST_ROW) begin
        r[9:5] = 5'd0;
        r[11]  = ~v[11];
      end else if (v[9:5] == 5'd31) begin
        r[9:5] = 5'd0;
      end else begin
        r[9:5] = v[9:5] + 5'd1;
      end
    end
    return r;
  endfunction

  assign w_wr         = lbus.ce & lbus.write;
  assign w_rd         = lbus.ce & lbus.read;
  assign w_acc_2007   = (w_wr | w_rd) && (lbus.ain == 3'd7);
  assign w_wr6_second = w_wr && (lbus.ain == 3'd6) && r_toggle;
  assign w_load_done  = r_pending && (r_cnt == 3'd1);

  assign w_x_dot  = (lbus.cycle[2:0] == 3'd7) &&
                    ((lbus.cycle <= 9'd255) || (lbus.cycle == 9'd327) || (lbus.cycle == 9'd335));
  assign w_y_dot  = (lbus.cycle == 9'd255);
  assign w_h_dot  = (lbus.cycle == 9'd256);
  assign w_v_copy = lbus.is_pre_render && (lbus.cycle >= 9'd279) && (lbus.cycle <= 9'd303);

  assign w_v_glitch = f_inc_y(f_inc_x(r_v));

  // Render operations landing on the same dot are chained into one update.
  always_comb begin
    w_v_render = r_v;
    if (w_x_dot) w_v_render = f_inc_x(w_v_render);
    if (w_y_dot) w_v_render = f_inc_y(w_v_render);
    if (w_h_dot) begin
      w_v_render[10]  = r_t[10];
      w_v_render[4:0] = r_t[4:0];
    end
    if (w_v_copy) begin
      w_v_render[14:11] = r_t[14:11];
      w_v_render[9:5]   = r_t[9:5];
    end
  end

  always_comb begin
    w_v_nxt       = r_v;
    w_t_nxt       = r_t;
    w_staged_nxt  = r_staged;
    w_fine_x_nxt  = r_fine_x;
    w_cnt_nxt     = r_cnt;
    w_toggle_nxt  = r_toggle;
    w_incr32_nxt  = r_incr32;
    w_pending_nxt = r_pending;
    if (lbus.ce) begin
      if (r_pending) begin
        w_cnt_nxt = r_cnt - 3'd1;
        if (r_cnt == 3'd1) w_pending_nxt = 1'b0;
      end
      if (w_wr) begin
        case (lbus.ain)
          3'd0: begin
            w_t_nxt[11:10] = lbus.din[1:0];
            w_incr32_nxt   = lbus.din[2];
          end
          3'd5: begin
            if (!r_toggle) begin
              w_t_nxt[4:0] = lbus.din[7:3];
              w_fine_x_nxt = lbus.din[2:0];
            end else begin
              w_t_nxt[9:5]   = lbus.din[7:3];
              w_t_nxt[14:12] = lbus.din[2:0];
            end
            w_toggle_nxt = ~r_toggle;
          end
          3'd6: begin
            if (!r_toggle) begin
              w_t_nxt[13:8] = lbus.din[5:0];
              w_t_nxt[14]   = 1'b0;
            end else begin
              w_t_nxt[7:0] = lbus.din;
              if (LP_DELAY != 3'd0) begin
                // A restage overrides the decrement above and restarts the countdown.
                w_staged_nxt  = {r_t[14:8], lbus.din};
                w_cnt_nxt     = LP_DELAY;
                w_pending_nxt = 1'b1;
              end
            end
            w_toggle_nxt = ~r_toggle;
          end
          default: ;
        endcase
      end
      if (w_rd && (lbus.ain == 3'd2)) w_toggle_nxt = 1'b0;

      if (w_load_done) begin
        w_v_nxt = r_staged;
      end else if (w_wr6_second && (LP_DELAY == 3'd0)) begin
        w_v_nxt = {r_t[14:8], lbus.din};
      end else if (w_acc_2007 && !lbus.is_rendering) begin
        w_v_nxt = r_v + (r_incr32 ? 15'd32 : 15'd1);
      end else if (w_acc_2007 && LP_GLITCH) begin
        w_v_nxt = w_v_glitch;
      end else if (lbus.is_rendering) begin
        w_v_nxt = w_v_render;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_v       <= '0;
      r_t       <= '0;
      r_staged  <= '0;
      r_fine_x  <= '0;
      r_cnt     <= '0;
      r_toggle  <= 1'b0;
      r_incr32  <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_v       <= w_v_nxt;
      r_t       <= w_t_nxt;
      r_staged  <= w_staged_nxt;
      r_fine_x  <= w_fine_x_nxt;
      r_cnt     <= w_cnt_nxt;
      r_toggle  <= w_toggle_nxt;
      r_incr32  <= w_incr32_nxt;
      r_pending <= w_pending_nxt;
    end
  end

  assign lbus.loopy          = r_v;
  assign lbus.fine_x_scroll  = r_fine_x;
  assign lbus.write_toggle   = r_toggle;
  assign lbus.v_load_pending = r_pending;

endmodule

// File: tb/tb_loopy_gen_v2.sv
// Directed bench for loopy_gen_v2 with default parameters (V_ROWS=30, delay 3, glitch on).
module tb_loopy_gen_v2;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  loopy_gen_v2_if bus();

  loopy_gen_v2 dut (
    .clk     (clk),
    .reset_n (reset_n),
    .lbus    (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input logic c, input logic rend, input logic pre, input logic [8:0] cyc,
                      input logic rd, input logic wr, input logic [2:0] a, input logic [7:0] d);
    bus.ce = c; bus.is_rendering = rend; bus.is_pre_render = pre; bus.cycle = cyc;
    bus.read = rd; bus.write = wr; bus.ain = a; bus.din = d;
    @(posedge clk);
    #1;
    bus.ce = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
    tick(1'b1, 1'b0, 1'b0, 9'd0, 1'b0, 1'b1, a, d);
  endtask

  task automatic idle();
    tick(1'b1, 1'b0, 1'b0, 9'd0, 1'b0, 1'b0, 3'd0, 8'd0);
  endtask

  task automatic load_t(input logic [14:0] tv);
    tick(1'b1, 1'b0, 1'b0, 9'd0, 1'b1, 1'b0, 3'd2, 8'd0);
    wr_reg(3'd0, {6'b0, tv[11:10]});
    wr_reg(3'd5, {tv[4:0], 3'b000});
    wr_reg(3'd5, {tv[9:5], tv[14:12]});
  endtask

  // t -> v through one horizontal and one vertical copy dot.
  task automatic set_v(input logic [14:0] tv);
    load_t(tv);
    tick(1'b1, 1'b1, 1'b0, 9'd256, 1'b0, 1'b0, 3'd0, 8'd0);
    tick(1'b1, 1'b1, 1'b1, 9'd280, 1'b0, 1'b0, 3'd0, 8'd0);
    total++;
    if (bus.loopy !== tv) begin bad++; $display("FAIL set_v got=%h exp=%h", bus.loopy, tv); end
  endtask

  task automatic test_reset();
    #3;
    total++; if (bus.loopy !== 15'h0) begin bad++; $display("FAIL rst_loopy got=%h exp=0", bus.loopy); end
    total++; if (bus.fine_x_scroll !== 3'h0) begin bad++; $display("FAIL rst_finex got=%h exp=0", bus.fine_x_scroll); end
    total++; if (bus.write_toggle !== 1'b0) begin bad++; $display("FAIL rst_toggle got=%b exp=0", bus.write_toggle); end
    total++; if (bus.v_load_pending !== 1'b0) begin bad++; $display("FAIL rst_pending got=%b exp=0", bus.v_load_pending); end
    #9 reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_toggle_read();
    wr_reg(3'd5, 8'hAD);
    total++; if (bus.write_toggle !== 1'b1) begin bad++; $display("FAIL tr_toggle1 got=%b exp=1", bus.write_toggle); end
    total++; if (bus.fine_x_scroll !== 3'd5) begin bad++; $display("FAIL tr_finex got=%h exp=5", bus.fine_x_scroll); end
    tick(1'b1, 1'b0, 1'b0, 9'd0, 1'b1, 1'b0, 3'd2, 8'd0);
    total++; if (bus.write_toggle !== 1'b0) begin bad++; $display("FAIL tr_toggle0 got=%b exp=0", bus.write_toggle); end
  endtask

  task automatic test_delayed_load();
    wr_reg(3'd6, 8'h21);
    total++; if (bus.write_toggle !== 1'b1) begin bad++; $display("FAIL dl_toggle1 got=%b exp=1", bus.write_toggle); end
    wr_reg(3'd6, 8'h08);
    total++; if (bus.write_toggle !== 1'b0) begin bad++; $display("FAIL dl_toggle0 got=%b exp=0", bus.write_toggle); end
    for (int i = 0; i < 3; i++) begin
      total++; if (bus.v_load_pending !== 1'b1) begin bad++; $display("FAIL dl_pend%0d got=%b exp=1", i, bus.v_load_pending); end
      total++; if (bus.loopy !== 15'h0) begin bad++; $display("FAIL dl_hold%0d got=%h exp=0", i, bus.loopy); end
      idle();
    end
    total++; if (bus.v_load_pending !== 1'b0) begin bad++; $display("FAIL dl_pend_end got=%b exp=0", bus.v_load_pending); end
    total++; if (bus.loopy !== 15'h2108) begin bad++; $display("FAIL dl_loaded got=%h exp=2108", bus.loopy); end
  endtask

  task automatic test_freeze();
    wr_reg(3'd6, 8'h05);
    wr_reg(3'd6, 8'h55);
    idle();
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0, 9'd0, 1'b0, 1'b0, 3'd0, 8'd0);
    total++; if (bus.v_load_pending !== 1'b1) begin bad++; $display("FAIL fr_pend got=%b exp=1", bus.v_load_pending); end
    idle();
    total++; if (bus.loopy !== 15'h2108) begin bad++; $display("FAIL fr_hold got=%h exp=2108", bus.loopy); end
    idle();
    total++; if (bus.loopy !== 15'h0555) begin bad++; $display("FAIL fr_loaded got=%h exp=0555", bus.loopy); end
  endtask

  task automatic test_restage();
    wr_reg(3'd6, 8'h11);
    wr_reg(3'd6, 8'h22);
    wr_reg(3'd6, 8'h33);
    wr_reg(3'd6, 8'h44);
    idle();
    idle();
    total++; if (bus.loopy !== 15'h0555) begin bad++; $display("FAIL rs_hold got=%h exp=0555", bus.loopy); end
    total++; if (bus.v_load_pending !== 1'b1) begin bad++; $display("FAIL rs_pend got=%b exp=1", bus.v_load_pending); end
    idle();
    total++; if (bus.loopy !== 15'h3344) begin bad++; $display("FAIL rs_loaded got=%h exp=3344", bus.loopy); end
  endtask

  task automatic test_incr();
    logic [14:0] exp_v [3];
    exp_v[0] = 15'h7FE0; exp_v[1] = 15'h0000; exp_v[2] = 15'h0020;
    set_v(15'h7FC0);
    wr_reg(3'd0, 8'h04);
    for (int i = 0; i < 3; i++) begin
      wr_reg(3'd7, 8'h00);
      total++; if (bus.loopy !== exp_v[i]) begin bad++; $display("FAIL inc32_%0d got=%h exp=%h", i, bus.loopy, exp_v[i]); end
    end
    wr_reg(3'd0, 8'h00);
    tick(1'b1, 1'b0, 1'b0, 9'd0, 1'b1, 1'b0, 3'd7, 8'd0);
    total++; if (bus.loopy !== 15'h0021) begin bad++; $display("FAIL inc1 got=%h exp=0021", bus.loopy); end
  endtask

  task automatic test_coarse_x();
    set_v(15'h001F);
    tick(1'b1, 1'b1, 1'b0, 9'd7, 1'b0, 1'b0, 3'd0, 8'd0);
    total++; if (bus.loopy !== 15'h0400) begin bad++; $display("FAIL cx_wrap got=%h exp=0400", bus.loopy); end
    tick(1'b1, 1'b1, 1'b0, 9'd263, 1'b0, 1'b0, 3'd0, 8'd0);
    total++; if (bus.loopy !== 15'h0400) begin bad++; $display("FAIL cx_263 got=%h exp=0400", bus.loopy); end
    tick(1'b1, 1'b1, 1'b0, 9'd327, 1'b0, 1'b0, 3'd0, 8'd0);
    total++; if (bus.loopy !== 15'h0401) begin bad++; $display("FAIL cx_327 got=%h exp=0401", bus.loopy); end
    tick(1'b1, 1'b0, 1'b0, 9'd335, 1'b0, 1'b0, 3'd0, 8'd0);
    total++; if (bus.loopy !== 15'h0401) begin bad++; $display("FAIL cx_norend got=%h exp=0401", bus.loopy); end
  endtask

  // Dot 255 also carries a coarse-X step, so Y bits and coarse X are checked separately.
  task automatic test_y();
    set_v(15'h73A0);
    tick(1'b1, 1'b1, 1'b0, 9'd255, 1'b0, 1'b0, 3'd0, 8'd0);
    total++; if ((bus.loopy & 15'h7FE0) !== 15'h0800) begin bad++; $display("FAIL y_row29 got=%h exp=0800", bus.loopy & 15'h7FE0); end
    total++; if (bus.loopy[4:0] !== 5'd1) begin bad++; $display("FAIL y_row29_cx got=%h exp=01", bus.loopy[4:0]); end
    set_v(15'h73E0);
    tick(1'b1, 1'b1, 1'b0, 9'd255, 1'b0, 1'b0, 3'd0, 8'd0);
    total++; if ((bus.loopy & 15'h7FE0) !== 15'h0000) begin bad++; $display("FAIL y_row31 got=%h exp=0000", bus.loopy & 15'h7FE0); end
    set_v(15'h1000);
    tick(1'b1, 1'b1, 1'b0, 9'd255, 1'b0, 1'b0, 3'd0, 8'd0);
    total++; if (bus.loopy !== 15'h2001) begin bad++; $display("FAIL y_fine got=%h exp=2001", bus.loopy); end
  endtask

  task automatic test_copies();
    set_v(15'h0000);
    load_t(15'h7FFF);
    tick(1'b1, 1'b1, 1'b0, 9'd256, 1'b0, 1'b0, 3'd0, 8'd0);
    total++; if (bus.loopy !== 15'h041F) begin bad++; $display("FAIL hcopy got=%h exp=041F", bus.loopy); end
    set_v(15'h0000);
    load_t(15'h7BFF);
    for (int c = 279; c <= 303; c++) tick(1'b1, 1'b1, 1'b1, 9'(c), 1'b0, 1'b0, 3'd0, 8'd0);
    total++; if (bus.loopy !== 15'h7BE0) begin bad++; $display("FAIL vcopy got=%h exp=7BE0", bus.loopy); end
  endtask

  task automatic test_glitch();
    set_v(15'h701F);
    tick(1'b1, 1'b1, 1'b0, 9'd7, 1'b1, 1'b0, 3'd7, 8'd0);
    total++; if (bus.loopy !== 15'h0420) begin bad++; $display("FAIL gl_dot7 got=%h exp=0420", bus.loopy); end
    set_v(15'h701F);
    tick(1'b1, 1'b1, 1'b0, 9'd255, 1'b0, 1'b1, 3'd7, 8'd0);
    total++; if (bus.loopy !== 15'h0420) begin bad++; $display("FAIL gl_dot255 got=%h exp=0420", bus.loopy); end
    set_v(15'h0000);
    tick(1'b1, 1'b1, 1'b0, 9'd100, 1'b1, 1'b0, 3'd7, 8'd0);
    total++; if (bus.loopy !== 15'h1001) begin bad++; $display("FAIL gl_dot100 got=%h exp=1001", bus.loopy); end
  endtask

  task automatic test_reset_mid();
    wr_reg(3'd6, 8'h12);
    wr_reg(3'd6, 8'h34);
    idle();
    reset_n = 1'b0;
    #2;
    total++; if (bus.v_load_pending !== 1'b0) begin bad++; $display("FAIL rm_pend got=%b exp=0", bus.v_load_pending); end
    total++; if (bus.loopy !== 15'h0) begin bad++; $display("FAIL rm_loopy got=%h exp=0", bus.loopy); end
    #2 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) idle();
    total++; if (bus.loopy !== 15'h0) begin bad++; $display("FAIL rm_after got=%h exp=0", bus.loopy); end
  endtask

  initial begin
    bus.ce = 1'b0; bus.is_rendering = 1'b0; bus.is_pre_render = 1'b0; bus.cycle = 9'd0;
    bus.read = 1'b0; bus.write = 1'b0; bus.ain = 3'd0; bus.din = 8'd0;
    test_reset();
    test_toggle_read();
    test_delayed_load();
    test_freeze();
    test_restage();
    test_incr();
    test_coarse_x();
    test_y();
    test_copies();
    test_glitch();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
